// File: rtl/tremolo_pkg.sv
// Shared types and constants for the tremolo stage.
package tremolo_pkg;

   // LFO waveform select; code 3 falls back to triangle in the decoder.
   typedef enum logic [1:0] {
      WAVE_TRI = 2'd0,
      WAVE_SQR = 2'd1,
      WAVE_SAW = 2'd2
   } wave_e;

   // Unity gain in unsigned Q0.15 (largest representable value below 1).
   localparam int unsigned Q15_ONE = 32767;

   // Width of the unsigned LFO level and of the gain.
   localparam int LVL_W = 15;

endpackage

// File: rtl/tremolo_lfo.sv
// Tremolo LFO: phase accumulator stepped once per accepted sample, restart
// on a rising edge of enable, and waveform decode to a 15-bit level.
module tremolo_lfo
   import tremolo_pkg::*;
#(
   parameter int PHASE_W = 24,
   parameter int RATE_W  = 16
) (
   input  logic               i_clk,
   input  logic               i_rst_n,
   input  logic               i_valid,
   input  logic               i_enable,
   input  logic [1:0]         i_wave,
   input  logic [RATE_W-1:0]  i_rate,
   output logic [LVL_W-1:0]   o_level
);

   logic [PHASE_W-1:0] r_phase;
   logic               r_en_hist;
   logic               w_accept;
   logic               w_restart;
   logic [PHASE_W-1:0] w_phase;
   logic [15:0]        w_t;

   assign w_accept  = i_valid & i_enable;
   // Enable just came on (history is only updated on valid cycles).
   assign w_restart = w_accept & ~r_en_hist;
   // Phase seen by this sample: forced to 0 on a restart.
   assign w_phase   = w_restart ? '0 : r_phase;
   assign w_t       = 16'(w_phase >> (PHASE_W - 16));

   // Advance the phase after the sample has used it; hold otherwise.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n)
         r_phase <= '0;
      else if (w_accept)
         r_phase <= w_phase + PHASE_W'(i_rate);
   end

   // Remember enable as seen on the last valid sample for edge detection.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n)
         r_en_hist <= 1'b0;
      else if (i_valid)
         r_en_hist <= i_enable;
   end

   // Decode the top 16 phase bits into the waveform level.
   always_comb begin
      o_level = w_t[15] ? ~w_t[14:0] : w_t[14:0];
      case (wave_e'(i_wave))
         WAVE_SQR: o_level = w_t[15] ? 15'd0 : 15'(Q15_ONE);
         WAVE_SAW: o_level = ~w_t[15:1];
         default:  o_level = w_t[15] ? ~w_t[14:0] : w_t[14:0];
      endcase
   end

endmodule

// File: rtl/effect_tremolo_lfo.sv
// Tremolo stage: gain from LFO level and depth, 2-cycle pipeline
// (stage 1: data/valid/enable/gain, stage 2: product or bypass).
// Optional feature macro: TREMOLO_SMOOTH_EN (depth ramps 1 step per sample).
module effect_tremolo_lfo
   import tremolo_pkg::*;
#(
   parameter int DATA_W  = 16,
   parameter int PHASE_W = 24,
   parameter int RATE_W  = 16,
   parameter int DEPTH_W = 8
) (
   input  logic                      i_clk,
   input  logic                      i_rst_n,
   input  logic                      i_valid,
   input  logic                      i_enable,
   input  logic [1:0]                i_wave,
   input  logic [RATE_W-1:0]         i_rate,
   input  logic [DEPTH_W-1:0]        i_depth,
   input  logic signed [DATA_W-1:0]  i_data,
   output logic signed [DATA_W-1:0]  o_data,
   output logic                      o_valid
);

   localparam int GP_W = LVL_W + DEPTH_W;      // depth * (1 - L) product
   localparam int MP_W = DATA_W + LVL_W + 1;   // sample * gain product

   logic [LVL_W-1:0]          w_level;
   logic [DEPTH_W-1:0]        w_depth_eff;
   logic [LVL_W-1:0]          w_lvl_inv;
   logic [GP_W-1:0]           w_gprod;
   logic [LVL_W-1:0]          w_gain;

   logic [1:0]                r_vld_pipe;
   logic signed [DATA_W-1:0]  r_data1;
   logic                      r_en1;
   logic [LVL_W-1:0]          r_gain1;
   logic signed [DATA_W-1:0]  r_data2;

   logic signed [MP_W-1:0]    w_da;
   logic signed [MP_W-1:0]    w_ga;
   logic signed [MP_W-1:0]    w_prod;

   tremolo_lfo #(
      .PHASE_W (PHASE_W),
      .RATE_W  (RATE_W)
   ) u_lfo (
      .i_clk    (i_clk),
      .i_rst_n  (i_rst_n),
      .i_valid  (i_valid),
      .i_enable (i_enable),
      .i_wave   (i_wave),
      .i_rate   (i_rate),
      .o_level  (w_level)
   );

`ifdef TREMOLO_SMOOTH_EN
   logic               w_accept;
   logic [DEPTH_W-1:0] r_depth_s;

   assign w_accept = i_valid & i_enable;

   // Effective depth for this sample: one step from the stored depth toward i_depth.
   always_comb begin
      w_depth_eff = r_depth_s;
      if (r_depth_s < i_depth)
         w_depth_eff = r_depth_s + 1'b1;
      else if (r_depth_s > i_depth)
         w_depth_eff = r_depth_s - 1'b1;
   end

   // Commit the stepped depth on accepted samples; collapse to 0 while disabled.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n)
         r_depth_s <= '0;
      else if (!i_enable)
         r_depth_s <= '0;
      else if (w_accept)
         r_depth_s <= w_depth_eff;
   end
`else
   assign w_depth_eff = i_depth;
`endif

   // G = 1 - depth*(1 - L), all in Q0.15; the >> DEPTH_W keeps G below 1.
   assign w_lvl_inv = LVL_W'(Q15_ONE) - w_level;
   assign w_gprod   = GP_W'(w_depth_eff) * GP_W'(w_lvl_inv);
   assign w_gain    = LVL_W'(Q15_ONE) - LVL_W'(w_gprod >> DEPTH_W);

   // Valid shift register: bit 0 = stage 1, bit 1 = output.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n)
         r_vld_pipe <= '0;
      else
         r_vld_pipe <= {r_vld_pipe[0], i_valid};
   end

   // Stage 1: capture sample, enable and gain.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_data1 <= '0;
         r_en1   <= 1'b0;
         r_gain1 <= '0;
      end else begin
         r_data1 <= i_data;
         r_en1   <= i_enable;
         r_gain1 <= w_gain;
      end
   end

   // Signed sample times non-negative gain; arithmetic shift floors toward -inf.
   assign w_da   = MP_W'(r_data1);
   assign w_ga   = MP_W'({1'b0, r_gain1});
   assign w_prod = w_da * w_ga;

   // Stage 2: modulated sample, or the raw sample when bypassed.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n)
         r_data2 <= '0;
      else if (r_vld_pipe[0])
         r_data2 <= r_en1 ? DATA_W'(w_prod >>> LVL_W) : r_data1;
   end

   assign o_data  = r_data2;
   assign o_valid = r_vld_pipe[1];

endmodule

// File: tb/tb_effect_tremolo_lfo.sv
// Bench for effect_tremolo_lfo (PHASE_W=16, RATE_W=16, default build).
module tb_effect_tremolo_lfo;

   localparam int DATA_W  = 16;
   localparam int PHASE_W = 16;
   localparam int RATE_W  = 16;
   localparam int DEPTH_W = 8;

   logic                     clk = 1'b0;
   logic                     rst_n;
   logic                     valid, enable;
   logic [1:0]               wave;
   logic [RATE_W-1:0]        rate;
   logic [DEPTH_W-1:0]       depth;
   logic signed [DATA_W-1:0] din;
   logic signed [DATA_W-1:0] dout;
   logic                     vout;

   effect_tremolo_lfo #(
      .DATA_W (DATA_W), .PHASE_W (PHASE_W), .RATE_W (RATE_W), .DEPTH_W (DEPTH_W)
   ) dut (
      .i_clk (clk), .i_rst_n (rst_n), .i_valid (valid), .i_enable (enable),
      .i_wave (wave), .i_rate (rate), .i_depth (depth), .i_data (din),
      .o_data (dout), .o_valid (vout)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;

   // Expected output per cycle slot (ring indexed by cycle number).
   bit             exp_v [16];
   int             exp_d [16];

   // Reference LFO state.
   int unsigned m_phase;
   bit          m_hist;

   function automatic int level(input int w, input int unsigned t);
      if (w == 1) return (t < 32768) ? 32767 : 0;
      if (w == 2) return 32767 - int'(t / 2);
      return (t < 32768) ? int'(t) : int'(65535 - t);
   endfunction

   // Reference for one input cycle; returns expected output when valid.
   function automatic int model(input bit v, input bit en, input int w,
                                input int unsigned r, input int d, input int x);
      int lv, g;
      longint p;
      int res;
      res = x;
      if (v) begin
         if (en) begin
            if (!m_hist) m_phase = 0;
            lv = level(w, m_phase);
            g  = 32767 - ((d * (32767 - lv)) / 256);
            p  = longint'(x) * longint'(g);
            res = int'(p >>> 15);
            m_phase = (m_phase + r) % 65536;
         end
         m_hist = en;
      end
      return res;
   endfunction

   task automatic chk_out();
      int i;
      i = cyc % 16;
      checks++;
      if (vout !== exp_v[i]) begin
         errors++;
         $display("FAIL valid cyc=%0d got=%b want=%b", cyc, vout, exp_v[i]);
      end
      if (exp_v[i]) begin
         checks++;
         if (int'(dout) != exp_d[i] || $isunknown(dout)) begin
            errors++;
            $display("FAIL data cyc=%0d got=%0d want=%0d", cyc, dout, exp_d[i]);
         end
      end
      exp_v[i] = 1'b0;
   endtask

   // One cycle: check current output, drive inputs, record expectation 2 cycles out.
   task automatic step(input bit v, input bit en, input int w, input int unsigned r,
                       input int d, input int x, input bit use_exp, input int xe);
      int mres;
      int j;
      chk_out();
      valid = v; enable = en; wave = 2'(w); rate = 16'(r); depth = 8'(d); din = 16'(x);
      mres = model(v, en, w, r, d, x);
      j = (cyc + 2) % 16;
      exp_v[j] = v;
      exp_d[j] = use_exp ? xe : mres;
      @(posedge clk);
      cyc++;
      @(negedge clk);
   endtask

   typedef struct {
      bit en; int w; int unsigned r; int d; int x; int exp;
   } vec_t;

   vec_t tbl [15];

   initial begin
      tbl[0]  = '{0, 0, 16'h0000,   0,   1234,   1234};
      tbl[1]  = '{0, 0, 16'h0000,   0, -32768, -32768};
      tbl[2]  = '{1, 1, 16'h4000, 255,  16384,  16383};
      tbl[3]  = '{1, 1, 16'h4000, 255,  16384,  16383};
      tbl[4]  = '{1, 1, 16'h4000, 255,  16384,     64};
      tbl[5]  = '{1, 1, 16'h4000, 255,  16384,     64};
      tbl[6]  = '{1, 1, 16'h4000, 255,  16384,  16383};
      tbl[7]  = '{0, 1, 16'h4000, 255,      5,      5};
      tbl[8]  = '{1, 1, 16'hC000, 255,  16384,  16383};
      tbl[9]  = '{1, 1, 16'hC000, 255,  16384,     64};
      tbl[10] = '{1, 1, 16'hC000, 255,  16384,     64};
      tbl[11] = '{1, 1, 16'hC000, 255,  16384,  16383};
      tbl[12] = '{0, 0, 16'h0000,   0,      0,      0};
      tbl[13] = '{1, 0, 16'h1234,   0,  16384,  16383};
      tbl[14] = '{1, 3, 16'h1234,   0, -32768, -32767};

      for (int i = 0; i < 16; i++) begin exp_v[i] = 0; exp_d[i] = 0; end
      m_phase = 0; m_hist = 0;
      rst_n = 1'b0; valid = 0; enable = 0; wave = 0; rate = 0; depth = 0; din = 0;
      repeat (3) @(negedge clk);
      checks++;
      if (vout !== 1'b0 || dout !== 16'sd0) begin
         errors++;
         $display("FAIL reset_state got v=%b d=%0d want v=0 d=0", vout, dout);
      end
      rst_n = 1'b1;
      @(negedge clk);

      // Table vectors, back to back.
      foreach (tbl[i])
         step(1, tbl[i].en, tbl[i].w, tbl[i].r, tbl[i].d, tbl[i].x, 1, tbl[i].exp);

      // Gaps: 3 idle cycles between samples leave the phase untouched.
      step(1, 0, 1, 16'h4000, 255, 7, 1, 7);
      for (int k = 0; k < 4; k++) begin
         step(1, 1, 1, 16'h4000, 255, 16384, 1, (k < 2) ? 16383 : 64);
         repeat (3) step(0, 1, 1, 16'h4000, 255, 0, 0, 0);
      end

      // Randomized stream against the reference model.
      for (int k = 0; k < 400; k++)
         step($urandom_range(0, 9) < 7, $urandom_range(0, 7) != 0,
              $urandom_range(0, 3), $urandom_range(0, 65535),
              $urandom_range(0, 255), int'($urandom_range(0, 65535)) - 32768, 0, 0);

      // Mid-stream asynchronous reset drops in-flight samples.
      step(1, 1, 0, 16'h0777, 200, 1000, 0, 0);
      step(1, 1, 0, 16'h0777, 200, 2000, 0, 0);
      #2;
      rst_n = 1'b0;
      #1;
      checks++;
      if (vout !== 1'b0 || dout !== 16'sd0) begin
         errors++;
         $display("FAIL async_reset got v=%b d=%0d want v=0 d=0", vout, dout);
      end
      for (int i = 0; i < 16; i++) exp_v[i] = 0;
      m_phase = 0; m_hist = 0;
      @(negedge clk);
      step(0, 0, 0, 0, 0, 0, 0, 0);
      rst_n = 1'b1;
      step(1, 1, 1, 16'h4000, 255, 16384, 1, 16383);
      step(1, 1, 1, 16'h4000, 255, 16384, 1, 16383);
      step(1, 1, 1, 16'h4000, 255, 16384, 1, 64);

      repeat (4) step(0, 0, 0, 0, 0, 0, 0, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
